// File: rtl/smbs_if.sv
// Serial broadcast switch bus: serial input strobe/data toward the switch,
// routed line fabric and header/status observation back from it.
interface smbs_if;
  logic             en;          // bit-valid strobe
  logic             serIn;       // serial data
  logic [3:0][3:0]  L;           // L[p][l]: line l of port p
  logic [0:5]       Q;           // header shift register contents
  logic [3:0]       PB;          // port enables
  logic [1:0]       LB;          // line select
  logic             busy;        // frame in progress
  logic             frame_done;  // one-cycle end-of-frame pulse

  // Link side: drives the serial stream, observes the fabric and status.
  modport master (
    output en,
    output serIn,
    input  L,
    input  Q,
    input  PB,
    input  LB,
    input  busy,
    input  frame_done
  );

  // Switch side: consumes the serial stream, drives the fabric and status.
  modport slave (
    input  en,
    input  serIn,
    output L,
    output Q,
    output PB,
    output LB,
    output busy,
    output frame_done
  );
endinterface

// File: rtl/smbs.sv
// Serial message broadcast switch.
// A frame is a start bit, a 6-bit header (PB[3..0] then LB[1..0], MSB first)
// and PAYLOAD_LEN payload bits. Every payload bit is steered, with zero
// latency, onto line LB of each port whose PB bit is set.
module smbs #(
  parameter int PAYLOAD_LEN = 8
) (
  input  logic   clk,
  input  logic   rst,
  smbs_if.slave  io
);

  // The payload count needs clog2(PAYLOAD_LEN+1) bits, but the same counter
  // also walks the six header bits, so it is never narrower than 3 bits.
  localparam int PAY_W = $clog2(PAYLOAD_LEN + 1);
  localparam int CNT_W = (PAY_W > 3) ? PAY_W : 3;

  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(5);
  localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [0:5]        q_r;
  logic [0:5]        q_nxt_s;
  logic              done_r;
  logic              done_nxt_s;
  logic [3:0]        pb_s;
  logic [1:0]        lb_s;
  logic              route_s;

  // State, header, counter and done-pulse registers; rst aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      q_r     <= 6'b000000;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      q_r     <= q_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Next-state logic: a bit is consumed only on en; without en all state holds.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    q_nxt_s     = q_r;
    done_nxt_s  = 1'b0;
    if (io.en) begin
      case (state_r)
        ST_IDLE: begin
          if (io.serIn) begin
            state_nxt_s = ST_HDR;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_HDR: begin
          // First header bit migrates to Q[0], so PB[3] ends up in Q[0].
          q_nxt_s = {q_r[1:5], io.serIn};
          if (cnt_r == HDR_LAST) begin
            state_nxt_s = ST_PAY;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end
        ST_PAY: begin
          if (cnt_r == PAY_LAST) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
            done_nxt_s  = 1'b1;
          end else begin
            cnt_nxt_s   = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = CNT_ZERO;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Header field decode and status outputs taken straight from the registers.
  always_comb begin
    pb_s          = {q_r[0], q_r[1], q_r[2], q_r[3]};
    lb_s          = {q_r[4], q_r[5]};
    io.Q          = q_r;
    io.PB         = pb_s;
    io.LB         = lb_s;
    io.busy       = (state_r != ST_IDLE);
    io.frame_done = done_r;
  end

  // Zero-latency routing: the live payload bit goes to line LB of every enabled port.
  always_comb begin
    io.L    = '0;
    route_s = io.serIn & io.en & (state_r == ST_PAY);
    for (int p = 0; p < 4; p++) begin
      for (int l = 0; l < 4; l++) begin
        io.L[p][l] = route_s & pb_s[p] & (lb_s == 2'(l));
      end
    end
  end

endmodule

// File: tb/tb_smbs.sv
// Directed bench for smbs: a frame-level reference model checked every cycle,
// plus hand-computed literal expectations for the documented scenarios.
module tb_smbs;
  localparam int PL = 8;

  logic clk;
  logic rst;
  smbs_if bus();

  smbs #(.PAYLOAD_LEN(PL)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus.slave)
  );

  int checks;
  int errors;
  bit check_on;

  // Frame-level model: inside a frame or not, bits consumed since the start
  // bit, header as received (first bit at the MSB) and the done pulse.
  bit        m_active;
  int        m_got;
  logic [5:0] m_hdr;
  bit        m_done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_l();
    logic [15:0] v;
    v = 16'h0000;
    if (m_active && (m_got >= 6) && bus.en && bus.serIn) begin
      for (int p = 0; p < 4; p++) begin
        if (m_hdr[2 + p]) v[p * 4 + int'(m_hdr[1:0])] = 1'b1;
      end
    end
    return v;
  endfunction

  // Model update on the same edge the DUT samples.
  always @(posedge clk) begin
    m_done = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_got    = 0;
      m_hdr    = 6'b000000;
    end else if (bus.en) begin
      if (!m_active) begin
        if (bus.serIn) begin
          m_active = 1'b1;
          m_got    = 0;
        end
      end else begin
        if (m_got < 6) m_hdr = {m_hdr[4:0], bus.serIn};
        m_got++;
        if (m_got == 6 + PL) begin
          m_active = 1'b0;
          m_got    = 0;
          m_done   = 1'b1;
        end
      end
    end
  end

  // Compare process: every output against the model, away from the active edge.
  always @(negedge clk) begin
    logic [5:0] qv;
    if (check_on) begin
      qv = bus.Q;
      chk("Q",          16'(qv),             16'(m_hdr));
      chk("PB",         16'(bus.PB),         16'(m_hdr[5:2]));
      chk("LB",         16'(bus.LB),         16'(m_hdr[1:0]));
      chk("busy",       16'(bus.busy),       16'(m_active));
      chk("frame_done", 16'(bus.frame_done), 16'(m_done));
      chk("L",          bus.L,               model_l());
    end
  end

  // Apply one cycle of inputs; returns mid-cycle with the inputs still applied.
  task automatic step(input logic e, input logic b);
    @(posedge clk);
    #1;
    bus.en    = e;
    bus.serIn = b;
    @(negedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [5:0] hdr);
    step(1'b1, 1'b1);
    for (int i = 5; i >= 0; i--) step(1'b1, hdr[i]);
  endtask

  task automatic send_pay(input logic [7:0] pay, input logic [15:0] lmask, input string nm);
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, pay[i]);
      chk(nm, bus.L, pay[i] ? lmask : 16'h0000);
    end
  endtask

  initial begin
    logic [5:0] qv;
    checks    = 0;
    errors    = 0;
    check_on  = 1'b0;
    rst       = 1'b1;
    bus.en    = 1'b0;
    bus.serIn = 1'b0;

    // 1: reset state
    @(posedge clk);
    #1;
    rst      = 1'b0;
    check_on = 1'b1;
    @(negedge clk);
    #1;
    qv = bus.Q;
    chk("rst_Q",    16'(qv),             16'h0000);
    chk("rst_busy", 16'(bus.busy),       16'h0000);
    chk("rst_L",    bus.L,               16'h0000);
    chk("rst_done", 16'(bus.frame_done), 16'h0000);

    // 2: header shift 1,0,0,1,0,1,1
    send_hdr(6'b001011);
    step(1'b0, 1'b0);
    qv = bus.Q;
    chk("hdr_Q",    16'(qv),       16'h000B);
    chk("hdr_PB",   16'(bus.PB),   16'h0002);
    chk("hdr_LB",   16'(bus.LB),   16'h0003);
    chk("hdr_busy", 16'(bus.busy), 16'h0001);
    send_pay(8'h00, 16'h0000, "t2_L");
    step(1'b0, 1'b0);
    chk("t2_done", 16'(bus.frame_done), 16'h0001);
    step(1'b0, 1'b0);
    chk("t2_done_clr", 16'(bus.frame_done), 16'h0000);

    // 3: PB=0001 LB=10, L[0][2] mirrors the payload
    send_hdr(6'b000110);
    send_pay(8'b10110011, 16'h0004, "t3_L");
    step(1'b0, 1'b1);
    chk("t3_done",   16'(bus.frame_done), 16'h0001);
    chk("t3_L_idle", bus.L,               16'h0000);
    step(1'b0, 1'b0);
    chk("t3_done_clr", 16'(bus.frame_done), 16'h0000);

    // 4: broadcast to line 3 of all ports, then back-to-back PB=0000 frame
    send_hdr(6'b111111);
    send_pay(8'hFF, 16'h8888, "t4_L");
    step(1'b1, 1'b1);
    chk("t4_done_b2b", 16'(bus.frame_done), 16'h0001);
    for (int i = 5; i >= 0; i--) step(1'b1, (6'b000011 >> i) & 6'b000001);
    send_pay(8'hFF, 16'h0000, "t4_L_none");
    step(1'b0, 1'b0);
    chk("t4_done_none", 16'(bus.frame_done), 16'h0001);

    // 5: stalls mid-header and mid-payload, PB=0100 LB=11
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      chk("t5_hstall_L", bus.L, 16'h0000);
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1);
      chk("t5_L", bus.L, 16'h0800);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      chk("t5_pstall_L",    bus.L,               16'h0000);
      chk("t5_pstall_done", 16'(bus.frame_done), 16'h0000);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1);
      chk("t5_L2", bus.L, 16'h0800);
    end
    step(1'b0, 1'b0);
    chk("t5_done", 16'(bus.frame_done), 16'h0001);

    // 6: reset at payload bit 4 aborts the frame
    send_hdr(6'b100000);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1);
      chk("t6_L", bus.L, 16'h1000);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.en    = 1'b0;
    bus.serIn = 1'b0;
    @(negedge clk);
    #1;
    qv = bus.Q;
    chk("t6_rst_busy", 16'(bus.busy),       16'h0000);
    chk("t6_rst_Q",    16'(qv),             16'h0000);
    chk("t6_rst_L",    bus.L,               16'h0000);
    chk("t6_rst_done", 16'(bus.frame_done), 16'h0000);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0);
      chk("t6_no_done", 16'(bus.frame_done), 16'h0000);
    end
    send_hdr(6'b001101);
    send_pay(8'b11010111, 16'h0022, "t6_L2");
    step(1'b0, 1'b0);
    chk("t6_done", 16'(bus.frame_done), 16'h0001);
    step(1'b0, 1'b0);

    check_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
